// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared constants and types for the Booth sequential
//               multiplier and its ripple-carry adder.
//               - WIDTH     : operand width (fixed by the 32-bit adder)
//               - state_t   : multiplier FSM states
//               - BOOTH_*   : Booth pair {Q[0], q_m1} codes that trigger
//                             an add or a subtract
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

  localparam int WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage : mul_pkg
`default_nettype wire

// File: rtl/rippleCarryAdder.sv
`default_nettype none
// ============================================================================
// Module      : rippleCarryAdder
// Description : 32-bit ripple-carry adder with signed overflow flag.
// Ports       : a, b     - addends (WIDTH bits)
//               cin      - carry in
//               result   - a + b + cin (WIDTH bits)
//               cout     - carry out of the MSB
//               overflow - two's-complement overflow of the sum
// Revision    : 1.0 - initial release
// ============================================================================
module rippleCarryAdder
  import mul_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign result[i]  = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign overflow = carry[WIDTH] ^ carry[WIDTH-1];

endmodule : rippleCarryAdder
`default_nettype wire

// File: rtl/booth_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : booth_seq_multiplier
// Description : Radix-2 Booth sequential signed multiplier, 32x32 -> 64.
//               One Booth step per clock through a shared 32-bit
//               ripple-carry adder; result after exactly WIDTH cycles.
// Ports       : clk          - clock, rising edge
//               rst          - asynchronous active-high reset
//               start        - request, sampled only while busy=0
//               multiplicand - signed operand M, captured on accept
//               multiplier   - signed operand Q, captured on accept
//               busy         - high while iterating
//               done         - one-cycle pulse when product is valid
//               product      - signed 64-bit result, held until next accept
// Revision    : 1.0 - initial release
// ============================================================================
module booth_seq_multiplier #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  import mul_pkg::*;

  localparam logic [CNT_W-1:0] ITER_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(1);

  state_t            state;
  logic [WIDTH-1:0]  acc;      // A: upper half of the running product
  logic [WIDTH-1:0]  q_reg;    // Q: multiplier, shifts into lower half
  logic              q_m1;     // bit shifted out of Q on the previous step
  logic [WIDTH-1:0]  m_reg;    // M: captured multiplicand
  logic [CNT_W-1:0]  count;

  // Adder interface
  logic [1:0]        booth_pair;
  logic              do_add;
  logic              do_sub;
  logic [WIDTH-1:0]  add_b;
  logic              add_cin;
  logic [WIDTH-1:0]  add_result;
  logic              add_overflow;
  logic              adder_cout_unused;

  // Next-step values
  logic [WIDTH-1:0]  sum_sel;
  logic              sgn;
  logic [WIDTH-1:0]  acc_next;
  logic [WIDTH-1:0]  q_next;

  assign booth_pair = {q_reg[0], q_m1};
  assign do_add     = (booth_pair == BOOTH_ADD);
  assign do_sub     = (booth_pair == BOOTH_SUB);

  // Subtraction is A + ~M + 1.
  assign add_b   = do_sub ? ~m_reg : m_reg;
  assign add_cin = do_sub;

  rippleCarryAdder u_adder (
    .a        (acc),
    .b        (add_b),
    .cin      (add_cin),
    .result   (add_result),
    .cout     (adder_cout_unused),
    .overflow (add_overflow)
  );

  always_comb begin
    sum_sel = acc;
    sgn     = acc[WIDTH-1];
    if (do_add || do_sub) begin
      sum_sel = add_result;
      // The true sign of the 33-bit sum is the 32-bit sign bit corrected
      // by overflow; this keeps M = -2^31 exact without a wider accumulator.
      sgn     = add_result[WIDTH-1] ^ add_overflow;
    end
    // Arithmetic shift right of {A, Q, q_m1}, with sgn as the new MSB.
    acc_next = {sgn, sum_sel[WIDTH-1:1]};
    q_next   = {sum_sel[0], q_reg[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      q_reg   <= '0;
      q_m1    <= 1'b0;
      m_reg   <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= multiplicand;
            q_reg <= multiplier;
            acc   <= '0;
            q_m1  <= 1'b0;
            count <= ITER_INIT;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_next;
          q_reg <= q_next;
          q_m1  <= q_reg[0];
          count <= count - ITER_LAST;
          if (count == ITER_LAST) begin
            // Final step: publish the post-shift {A, Q} directly.
            product <= {acc_next, q_next};
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule : booth_seq_multiplier
`default_nettype wire

// File: tb/tb_booth_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_seq_multiplier
// Description : Self-checking bench for booth_seq_multiplier. A table of
//               operand/product vectors plus hand-written sequences for
//               ignored start, async reset and back-to-back operation.
//               Expected products are queued at accept and compared when
//               done pulses, together with the accept-to-done latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_seq_multiplier;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0]   m;
    logic [W-1:0]   q;
    logic [2*W-1:0] exp;
  } vec_t;

  typedef struct {
    logic [2*W-1:0] exp;
    int             acc_cyc;
  } sb_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [W-1:0]   multiplicand = '0;
  logic [W-1:0]   multiplier = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  sb_t sb[$];
  logic prev_done = 1'b0;
  logic prev_busy = 1'b0;
  logic [2*W-1:0] prev_product = '0;
  int run_product_changes = 0;

  booth_seq_multiplier #(.WIDTH(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%016h required=0x%016h", name, act, req);
    end
  endtask

  // Scoreboard monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: actual=done required=no_done at cycle %0d", cyc);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check("product", product, e.exp);
        check("latency", 64'(cyc - e.acc_cyc), 64'd32);
        check("busy_in_done_cycle", {63'd0, busy}, 64'd0);
      end
      if (prev_done) begin
        checks++;
        failures++;
        $display("FAIL done_width: actual=2+ cycles required=1 cycle");
      end
    end
    if (busy && prev_busy && product !== prev_product) run_product_changes++;
    prev_done    = done;
    prev_busy    = busy;
    prev_product = product;
  end

  // Drive one request and register its expected product.
  task automatic start_op(input logic [W-1:0] m, input logic [W-1:0] q,
                          input logic [2*W-1:0] exp);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sb.push_back('{exp: exp, acc_cyc: cyc});
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: actual=%0d pending results required=0", sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] m, input logic [W-1:0] q);
    logic signed [2*W-1:0] sm, sq;
    sm = {{W{m[W-1]}}, m};
    sq = {{W{q[W-1]}}, q};
    return sm * sq;
  endfunction

  initial begin
    vec_t vecs[$];
    int   busy_low;
    int   first_acc;
    int   n;
    logic [W-1:0] rm, rq;

    vecs.push_back('{m: 32'd7,        q: 32'hFFFFFFFD, exp: 64'hFFFFFFFFFFFFFFEB});
    vecs.push_back('{m: 32'h80000000, q: 32'h80000000, exp: 64'h4000000000000000});
    vecs.push_back('{m: 32'h80000000, q: 32'h00000001, exp: 64'hFFFFFFFF80000000});
    vecs.push_back('{m: 32'h7FFFFFFF, q: 32'h7FFFFFFF, exp: 64'h3FFFFFFF00000001});
    vecs.push_back('{m: 32'h00000000, q: 32'hFFFFFFFF, exp: 64'h0000000000000000});
    vecs.push_back('{m: 32'hFFFFFFFF, q: 32'hFFFFFFFF, exp: 64'h0000000000000001});
    vecs.push_back('{m: 32'h00000001, q: 32'h80000000, exp: 64'hFFFFFFFF80000000});
    vecs.push_back('{m: 32'h12345678, q: 32'h0000FFFF, exp: 64'h00001234_4443A988});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_product", product, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Busy must stay high for the whole run of the first operation.
    start_op(vecs[0].m, vecs[0].q, vecs[0].exp);
    busy_low = 0;
    for (int i = 0; i < 31; i++) begin
      if (!busy) busy_low++;
      @(posedge clk); #1;
    end
    check("busy_during_run", 64'(busy_low), 64'd0);
    wait_empty(100);

    for (int i = 1; i < vecs.size(); i++) begin
      start_op(vecs[i].m, vecs[i].q, vecs[i].exp);
      wait_empty(100);
    end

    // A few random operands against the behavioural model.
    for (int i = 0; i < 4; i++) begin
      rm = $urandom;
      rq = $urandom;
      start_op(rm, rq, model(rm, rq));
      wait_empty(100);
    end

    // start while busy is ignored; product must not move during RUN.
    run_product_changes = 0;
    start_op(32'd5, 32'd6, 64'd30);
    repeat (9) begin @(posedge clk); #1; end
    multiplicand = 32'd9;
    multiplier   = 32'd9;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_empty(100);
    repeat (3) begin @(posedge clk); #1; end
    check("product_stable_in_run", 64'(run_product_changes), 64'd0);
    check("product_held_after_done", product, 64'd30);

    // Async reset mid-operation discards the run.
    start_op(32'h12345678, 32'h0000FFFF, 64'h00001234_4443A988);
    repeat (14) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("async_rst_busy", {63'd0, busy}, 64'd0);
    check("async_rst_done", {63'd0, done}, 64'd0);
    check("async_rst_product", product, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    // Monitor flags any done seen here as unexpected.
    repeat (40) begin @(posedge clk); #1; end
    start_op(32'd2, 32'd3, 64'd6);
    wait_empty(100);

    // Back-to-back with start held high.
    multiplicand = 32'hFFFFFFF6;  // -10
    multiplier   = 32'd11;
    start        = 1'b1;
    @(posedge clk); #1;
    sb.push_back('{exp: 64'hFFFFFFFFFFFFFF92, acc_cyc: cyc});
    first_acc    = cyc;
    multiplicand = 32'h00010000;
    multiplier   = 32'hFFFF0000;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy_after_reaccept", {63'd0, busy}, 64'd1);
    check("b2b_done_dropped", {63'd0, done}, 64'd0);
    sb.push_back('{exp: 64'hFFFFFFFF00000000, acc_cyc: cyc});
    check("b2b_accept_spacing", 64'(cyc - first_acc), 64'd33);
    wait_empty(100);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_booth_seq_multiplier
`default_nettype wire
